// File: rtl/fpu_issue_scoreboard.sv
// fpu_issue_scoreboard
//   Issue controller between FP decode and the FPU execution unit. Accepts
//   decoded FP ops in order, tracks their destination registers in a pending
//   bitmap, stalls on RAW/WAW hazards, and serialises fdiv/fsqrt. Results come
//   back in order and are written to the FP register file one cycle after
//   completion.
//
// Ports
//   clk, rst_l          clock (rising edge), asynchronous active-low reset
//   instr_valid         decoded FP op present
//   fs_rden[2:0]        {fs3,fs2,fs1} source read enables
//   fs1/2/3_addr        source register addresses
//   fd_addr, fd_wen     destination register and its write enable
//   is_long             op is fdiv/fsqrt
//   issue_ready         execution unit can accept
//   instr_ready         op accepted this cycle (issue_valid & issue_ready)
//   issue_valid         op presented to execution unit
//   cmpl_valid          oldest outstanding op finished, result on cmpl_data
//   flush               drop all tracking state at the next edge
//   wb_en/addr/data     FP register-file write port (registered)
//   outstanding         queue occupancy
//   halt_req            a long op is in flight
//   cmpl_err            sticky: completion seen with nothing outstanding
module fpu_issue_scoreboard #(
  parameter int FPLEN = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             instr_valid,
  input  logic [2:0]       fs_rden,
  input  logic [AW-1:0]    fs1_addr,
  input  logic [AW-1:0]    fs2_addr,
  input  logic [AW-1:0]    fs3_addr,
  input  logic [AW-1:0]    fd_addr,
  input  logic             fd_wen,
  input  logic             is_long,
  input  logic             issue_ready,
  output logic             instr_ready,
  output logic             issue_valid,
  input  logic             cmpl_valid,
  input  logic [FPLEN-1:0] cmpl_data,
  input  logic             flush,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [FPLEN-1:0] wb_data,
  output logic [CW-1:0]    outstanding,
  output logic             halt_req,
  output logic             cmpl_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [NREGS-1:0]  pend;
  logic              long_busy;

  logic hazard, stall, accept, pop, q_empty, q_full;
  entry_t head;

  assign q_empty = (cnt == '0);
  assign q_full  = (cnt == CW'(DEPTH));
  assign head    = q[rd_ptr];

  always_comb begin
    hazard = fd_wen & pend[fd_addr];
    if (fs_rden[0]) hazard = hazard | pend[fs1_addr];
    if (fs_rden[1]) hazard = hazard | pend[fs2_addr];
    if (fs_rden[2]) hazard = hazard | pend[fs3_addr];
  end

  // Occupancy is the registered count, so a pop in the same cycle never
  // opens a slot for a push while full.
  assign stall       = hazard | q_full | long_busy | (is_long & ~q_empty);
  assign issue_valid = instr_valid & ~stall & ~flush;
  assign instr_ready = issue_valid & issue_ready;
  assign accept      = instr_ready;
  assign pop         = cmpl_valid & ~q_empty & ~flush;

  assign outstanding = cnt;
  assign halt_req    = long_busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Queue storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (accept) q[wr_ptr] <= '{addr: fd_addr, wen: fd_wen};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A pending bit clears at the end of its wb_en cycle; the set from a new
  // accept is ordered last, though a WAW stall keeps the two from colliding.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend <= '0;
    end else if (flush) begin
      pend <= '0;
    end else begin
      if (wb_en)           pend[wb_addr] <= 1'b0;
      if (accept & fd_wen) pend[fd_addr] <= 1'b1;
    end
  end

  // A long op only issues into an empty queue and blocks further issue, so
  // it is the last entry: popping the final entry ends the long phase.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      long_busy <= 1'b0;
    end else if (flush) begin
      long_busy <= 1'b0;
    end else if (accept & is_long) begin
      long_busy <= 1'b1;
    end else if (pop && cnt == CW'(1) && !accept) begin
      long_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= pop & head.wen;
      if (pop) begin
        wb_addr <= head.addr;
        wb_data <= cmpl_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                     cmpl_err <= 1'b0;
    else if (cmpl_valid & q_empty)  cmpl_err <= 1'b1;
  end

endmodule
